uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte FIFO directly upstream of the UART transmitter inside uart_main.
- Accepts bytes from host logic on a simple write strobe and buffers them.
- Presents them first-word-fall-through on the transmitter's tx_input_data / tx_input_data_valid inputs.
- Pops one byte per accepted handshake with tx_output_ready, so the host never waits on the serial line.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2 and at least 2.
- AFULL_LEVEL, 12, occupancy at or above which wr_almost_full asserts; range 1..DEPTH.
- DATA_W, 8, byte width; fixed at 8 to match the transmitter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  drain enable; when 0, the output side presents nothing.
- wr_data  in  DATA_W  byte to enqueue.
- wr_en  in  1  enqueue strobe, one byte per cycle.
- wr_full  out  1  FIFO full; writes are ignored.
- wr_almost_full  out  1  count >= AFULL_LEVEL.
- overflow  out  1  sticky: a write was attempted while full.
- ovf_clr  in  1  clears overflow.
- tx_input_data  out  DATA_W  head-of-queue byte, to the transmitter.
- tx_input_data_valid  out  1  head byte valid, to the transmitter.
- tx_output_ready  in  1  transmitter ready; a handshake pops the head.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (async assert, synchronous release):
  - rd_ptr = wr_ptr = 0, count = 0, overflow = 0.
  - Outputs: wr_full = 0, wr_almost_full = 0, empty = 1, tx_input_data_valid = 0, tx_input_data = 8'h00.
  - Memory contents are not reset.
  - Reset mid-operation discards all queued bytes immediately; the transmitter may be mid-frame and completes that frame on its own.
- Storage: register array of DEPTH bytes. wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Push = wr_en && !wr_full. On push: mem[wr_ptr] <= wr_data, wr_ptr++.
- Pop = tx_input_data_valid && tx_output_ready. On pop: rd_ptr++.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - Allowed at any non-full, non-empty occupancy; count unchanged.
  - When full: the write is rejected even if a pop occurs in the same cycle; the pop proceeds and overflow sets.
  - When empty: no pop can occur because valid = 0; the push lands and count goes to 1.
- Output side (first-word-fall-through):
  - tx_input_data = mem[rd_ptr], asynchronous read; 8'h00 while empty.
  - tx_input_data_valid = enable && !empty, combinational from registered state.
  - A byte written in cycle N is visible, with valid high, from cycle N+1.
  - A byte stays on tx_input_data, stable, until popped. Deasserting enable holds the queue with no pop and no data loss.
- Status flags:
  - wr_full = (count == DEPTH).
  - wr_almost_full = (count >= AFULL_LEVEL).
  - empty = (count == 0).
  - All three derive from the registered count; no extra latency.
- Overflow:
  - Set on wr_en && wr_full.
  - Cleared on ovf_clr. If set and clear fall in the same cycle, set wins.
  - The rejected byte is dropped and FIFO contents are unaffected.
- Transmitter contract: the transmitter samples tx_input_data on the handshake edge and drops tx_output_ready until its frame completes. The FIFO must not depend on ready staying low; back-to-back ready pops back-to-back bytes.
- wr_en while rst is high is ignored.

Test Plan:
- Reset, then write 8'hdf with enable=1 and tx_output_ready=0 → next cycle tx_input_data=8'hdf, valid=1, count=1, empty=0.
- DEPTH=4: write 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 with ready=0 → wr_full=1 after the 4th write, count=4, overflow=1; ovf_clr then clears overflow; popped order is 11, 22, 33, 44 and 55 never appears.
- DEPTH=4 holding 4 bytes: pulse ready and write 8'h66 in the same cycle → pop of 8'h11, write rejected, overflow=1, count=3.
- Occupancy 2: push and pop in the same cycle → count stays 2. Repeat across 9 cycles to check pointer wrap: output sequence matches input order, no duplicates or skips.
- Queue 8'hdf, 8'hbf; hold enable=0 for 20 cycles with ready=1 → valid=0, count stays 2. Set enable=1 → both bytes pop in order.
- Load 3 bytes, assert rst asynchronously mid-cycle → count=0, valid=0, empty=1 immediately, before the next clk edge. After release, a new write of 8'hce appears as head.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; first-word-fall-through output.
// Host pushes on a write strobe, transmitter pops on valid/ready handshakes.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12,
    parameter int DATA_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_en,
    output logic                       wr_full,
    output logic                       wr_almost_full,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic [DATA_W-1:0]          tx_input_data,
    output logic                       tx_input_data_valid,
    input  logic                       tx_output_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              push, pop;

    assign wr_full             = (count_q == CW'(DEPTH));
    assign wr_almost_full      = (count_q >= CW'(AFULL_LEVEL));
    assign empty               = (count_q == '0);
    assign count               = count_q;
    assign overflow            = ovf_q;
    assign tx_input_data_valid = enable && !empty;
    assign tx_input_data       = empty ? '0 : mem_q[rd_ptr_q];

    // A full FIFO rejects the write even when a pop frees a slot this cycle.
    assign push = wr_en && !wr_full;
    assign pop  = tx_input_data_valid && tx_output_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        // Set has priority over a same-cycle clear.
        if (wr_en && wr_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DEPTH=4, AFULL_LEVEL=3.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       wr_full;
    logic       wr_almost_full;
    logic       overflow;
    logic       ovf_clr;
    logic [7:0] tx_input_data;
    logic       tx_input_data_valid;
    logic       tx_output_ready;
    logic [2:0] count;
    logic       empty;

    int nvec = 0;
    int nerr = 0;

    uart_tx_fifo #(
        .DEPTH       (4),
        .AFULL_LEVEL (3),
        .DATA_W      (8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .wr_data             (wr_data),
        .wr_en               (wr_en),
        .wr_full             (wr_full),
        .wr_almost_full      (wr_almost_full),
        .overflow            (overflow),
        .ovf_clr             (ovf_clr),
        .tx_input_data       (tx_input_data),
        .tx_input_data_valid (tx_input_data_valid),
        .tx_output_ready     (tx_output_ready),
        .count               (count),
        .empty               (empty)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        cycle();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        ovf_clr = 1'b0; tx_output_ready = 1'b0;
        cycle(); cycle();
        nvec++; if (count !== 3'd0) begin nerr++;
            $display("FAIL reset_count got %0d want 0", count); end
        nvec++; if (empty !== 1'b1) begin nerr++;
            $display("FAIL reset_empty got %b want 1", empty); end
        nvec++; if (wr_full !== 1'b0 || wr_almost_full !== 1'b0) begin nerr++;
            $display("FAIL reset_flags got full=%b afull=%b want 0 0",
                     wr_full, wr_almost_full); end
        nvec++; if (tx_input_data_valid !== 1'b0 || tx_input_data !== 8'h00) begin nerr++;
            $display("FAIL reset_out got v=%b d=%h want 0 00",
                     tx_input_data_valid, tx_input_data); end
        nvec++; if (overflow !== 1'b0) begin nerr++;
            $display("FAIL reset_ovf got %b want 0", overflow); end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_fwft();
        enable = 1'b1; tx_output_ready = 1'b0;
        push(8'hdf);
        nvec++; if (tx_input_data !== 8'hdf || tx_input_data_valid !== 1'b1) begin nerr++;
            $display("FAIL fwft_head got v=%b d=%h want 1 df",
                     tx_input_data_valid, tx_input_data); end
        nvec++; if (count !== 3'd1 || empty !== 1'b0) begin nerr++;
            $display("FAIL fwft_count got cnt=%0d empty=%b want 1 0", count, empty); end
        tx_output_ready = 1'b1;
        cycle();
        tx_output_ready = 1'b0;
        nvec++; if (count !== 3'd0 || empty !== 1'b1 || tx_input_data_valid !== 1'b0
                    || tx_input_data !== 8'h00) begin nerr++;
            $display("FAIL fwft_pop got cnt=%0d e=%b v=%b d=%h want 0 1 0 00",
                     count, empty, tx_input_data_valid, tx_input_data); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp [3];
        exp[0] = 8'h22; exp[1] = 8'h33; exp[2] = 8'h44;
        enable = 1'b1; tx_output_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33);
        nvec++; if (count !== 3'd3 || wr_almost_full !== 1'b1 || wr_full !== 1'b0) begin nerr++;
            $display("FAIL afull got cnt=%0d af=%b f=%b want 3 1 0",
                     count, wr_almost_full, wr_full); end
        push(8'h44);
        nvec++; if (count !== 3'd4 || wr_full !== 1'b1 || overflow !== 1'b0) begin nerr++;
            $display("FAIL full got cnt=%0d f=%b ovf=%b want 4 1 0",
                     count, wr_full, overflow); end
        ovf_clr = 1'b1;
        push(8'h55);
        ovf_clr = 1'b0;
        nvec++; if (overflow !== 1'b1 || count !== 3'd4 || tx_input_data !== 8'h11) begin nerr++;
            $display("FAIL ovf_set got ovf=%b cnt=%0d d=%h want 1 4 11",
                     overflow, count, tx_input_data); end
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        nvec++; if (overflow !== 1'b0) begin nerr++;
            $display("FAIL ovf_clr got %b want 0", overflow); end
        tx_output_ready = 1'b1;
        push(8'h66);
        tx_output_ready = 1'b0;
        nvec++; if (count !== 3'd3 || overflow !== 1'b1 || tx_input_data !== 8'h22) begin nerr++;
            $display("FAIL full_pushpop got cnt=%0d ovf=%b d=%h want 3 1 22",
                     count, overflow, tx_input_data); end
        tx_output_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nvec++; if (tx_input_data !== exp[i]) begin nerr++;
                $display("FAIL drain_%0d got %h want %h", i, tx_input_data, exp[i]); end
            cycle();
        end
        tx_output_ready = 1'b0;
        nvec++; if (count !== 3'd0 || empty !== 1'b1) begin nerr++;
            $display("FAIL drain_end got cnt=%0d e=%b want 0 1", count, empty); end
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        enable = 1'b1; tx_output_ready = 1'b0;
        push(8'ha0); push(8'ha1);
        for (int i = 0; i < 9; i++) begin
            want = 8'ha0 + 8'(i);
            wr_en = 1'b1; wr_data = 8'ha2 + 8'(i); tx_output_ready = 1'b1;
            nvec++; if (tx_input_data !== want) begin nerr++;
                $display("FAIL b2b_head_%0d got %h want %h", i, tx_input_data, want); end
            cycle();
            nvec++; if (count !== 3'd2) begin nerr++;
                $display("FAIL b2b_count_%0d got %0d want 2", i, count); end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            want = 8'ha9 + 8'(i);
            nvec++; if (tx_input_data !== want) begin nerr++;
                $display("FAIL b2b_tail_%0d got %h want %h", i, tx_input_data, want); end
            cycle();
        end
        tx_output_ready = 1'b0;
        nvec++; if (empty !== 1'b1) begin nerr++;
            $display("FAIL b2b_empty got %b want 1", empty); end
    endtask

    task automatic test_enable_hold();
        enable = 1'b0; tx_output_ready = 1'b1;
        push(8'hdf); push(8'hbf);
        repeat (20) cycle();
        nvec++; if (tx_input_data_valid !== 1'b0 || count !== 3'd2) begin nerr++;
            $display("FAIL hold got v=%b cnt=%0d want 0 2", tx_input_data_valid, count); end
        enable = 1'b1;
        #1;
        nvec++; if (tx_input_data_valid !== 1'b1 || tx_input_data !== 8'hdf) begin nerr++;
            $display("FAIL hold_first got v=%b d=%h want 1 df",
                     tx_input_data_valid, tx_input_data); end
        cycle();
        nvec++; if (tx_input_data !== 8'hbf || count !== 3'd1) begin nerr++;
            $display("FAIL hold_second got d=%h cnt=%0d want bf 1", tx_input_data, count); end
        cycle();
        tx_output_ready = 1'b0;
        nvec++; if (empty !== 1'b1) begin nerr++;
            $display("FAIL hold_empty got %b want 1", empty); end
    endtask

    task automatic test_async_reset();
        enable = 1'b1; tx_output_ready = 1'b0;
        push(8'h01); push(8'h02); push(8'h03);
        #2;
        rst = 1'b1;
        #1;
        nvec++; if (count !== 3'd0 || tx_input_data_valid !== 1'b0 || empty !== 1'b1) begin nerr++;
            $display("FAIL async_rst got cnt=%0d v=%b e=%b want 0 0 1",
                     count, tx_input_data_valid, empty); end
        wr_en = 1'b1; wr_data = 8'h77;
        cycle();
        wr_en = 1'b0;
        rst = 1'b0;
        cycle();
        nvec++; if (count !== 3'd0) begin nerr++;
            $display("FAIL rst_write got cnt=%0d want 0", count); end
        push(8'hce);
        nvec++; if (tx_input_data !== 8'hce || count !== 3'd1 || tx_input_data_valid !== 1'b1) begin nerr++;
            $display("FAIL post_rst got d=%h cnt=%0d v=%b want ce 1 1",
                     tx_input_data, count, tx_input_data_valid); end
    endtask

    initial begin
        test_reset();
        test_fwft();
        test_overflow();
        test_back_to_back();
        test_enable_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
